// File: rtl/aixh_mxc_inner_bwdcollect_if.sv
// aixh_mxc_inner_bwdcollect_if: backward-collect bus bundle.
//   i_bwd_vld/i_bwd_dat : per-lane backward input, lane i at [DW*i +: DW]
//   o_vld/o_dat/o_lane  : collected result and its source lane
//   i_rdy               : downstream ready
//   o_ovf/i_ovf_clr     : sticky per-lane overflow flags and their clear
interface aixh_mxc_inner_bwdcollect_if #(
   parameter int NLANE = 4,
   parameter int DW = 32
);
   localparam int LW = $clog2(NLANE);
   logic [NLANE-1:0]    i_bwd_vld;
   logic [NLANE*DW-1:0] i_bwd_dat;
   logic                o_vld;
   logic [DW-1:0]       o_dat;
   logic [LW-1:0]       o_lane;
   logic                i_rdy;
   logic [NLANE-1:0]    o_ovf;
   logic                i_ovf_clr;
   modport master (output i_bwd_vld, i_bwd_dat, i_rdy, i_ovf_clr, input o_vld, o_dat, o_lane, o_ovf);
   modport slave (input i_bwd_vld, i_bwd_dat, i_rdy, i_ovf_clr, output o_vld, o_dat, o_lane, o_ovf);
endinterface

// File: rtl/aixh_mxc_inner_bwdcollect.sv
// aixh_mxc_inner_bwdcollect: per-lane FIFOs merged round-robin into one registered output stream.
//   aixh_core_clk2x : clock, rising edge
//   aixh_core_rst2x : synchronous active-high reset
//   bus (slave)     : lane inputs, collected output with ready, overflow flags
// Optional overflow flags: define AIXH_MXC_BWDCOL_OVF_EN.
module aixh_mxc_inner_bwdcollect #(
   parameter int NLANE = 4,
   parameter int DW = 32,
   parameter int DEPTH = 4
) (
   input logic aixh_core_clk2x,
   input logic aixh_core_rst2x,
   aixh_mxc_inner_bwdcollect_if.slave bus
);
   localparam int LW = $clog2(NLANE);
   localparam int AW = $clog2(DEPTH);
   logic [DW-1:0] mem [NLANE][DEPTH];
   logic [AW-1:0] wp [NLANE];
   logic [AW-1:0] rp [NLANE];
   logic [AW:0] cnt [NLANE];
   logic [NLANE-1:0] ne, full, pop, push;
   logic [LW-1:0] ptr, gnt;
   logic found, ld;
   int idx;
   always_comb begin
      for (int i = 0; i < NLANE; i++) begin
         ne[i] = cnt[i] != '0;
         full[i] = cnt[i] == (AW+1)'(DEPTH);
      end
   end
   // first non-empty lane at or after ptr, wrapping
   always_comb begin
      gnt = '0;
      found = 1'b0;
      idx = 0;
      for (int k = 0; k < NLANE; k++) begin
         idx = (int'(ptr) + k) % NLANE;
         if (!found && ne[idx]) begin
            found = 1'b1;
            gnt = LW'(idx);
         end
      end
   end
   assign ld = (!bus.o_vld || bus.i_rdy) && found;
   assign pop = ld ? NLANE'(1) << gnt : '0;
   // a full lane still accepts when it is popped in the same cycle
   assign push = bus.i_bwd_vld & (~full | pop);
   always_ff @(posedge aixh_core_clk2x) begin
      for (int i = 0; i < NLANE; i++)
         if (push[i]) mem[i][wp[i]] <= bus.i_bwd_dat[DW*i +: DW];
   end
   always_ff @(posedge aixh_core_clk2x) begin
      for (int i = 0; i < NLANE; i++) begin
         if (aixh_core_rst2x) begin
            wp[i] <= '0;
            rp[i] <= '0;
            cnt[i] <= '0;
         end else begin
            if (push[i]) wp[i] <= wp[i] + 1'b1;
            if (pop[i]) rp[i] <= rp[i] + 1'b1;
            cnt[i] <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
         end
      end
   end
   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x) begin
         bus.o_vld <= 1'b0;
         bus.o_dat <= '0;
         bus.o_lane <= '0;
         ptr <= '0;
      end else if (ld) begin
         bus.o_vld <= 1'b1;
         bus.o_dat <= mem[gnt][rp[gnt]];
         bus.o_lane <= gnt;
         ptr <= gnt == LW'(NLANE-1) ? '0 : gnt + 1'b1;
      end else if (bus.i_rdy) begin
         bus.o_vld <= 1'b0;
      end
   end
`ifdef AIXH_MXC_BWDCOL_OVF_EN
   // a drop in the same cycle as a clear leaves the flag set
   always_ff @(posedge aixh_core_clk2x) begin
      if (aixh_core_rst2x) bus.o_ovf <= '0;
      else bus.o_ovf <= (bus.i_ovf_clr ? '0 : bus.o_ovf) | (bus.i_bwd_vld & full & ~pop);
   end
`else
   assign bus.o_ovf = '0;
`endif
endmodule

// File: tb/tb_aixh_mxc_inner_bwdcollect.sv
// tb_aixh_mxc_inner_bwdcollect: directed checks of latency, round-robin, stall, overflow and reset.
module tb_aixh_mxc_inner_bwdcollect;
`ifdef AIXH_MXC_BWDCOL_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   aixh_mxc_inner_bwdcollect_if #(.NLANE(4), .DW(32)) bus ();
   aixh_mxc_inner_bwdcollect #(.NLANE(4), .DW(32), .DEPTH(4)) dut (
      .aixh_core_clk2x(clk),
      .aixh_core_rst2x(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic put(input int l, input logic [31:0] v);
      bus.i_bwd_vld[l] = 1'b1;
      bus.i_bwd_dat[32*l +: 32] = v;
   endtask
   task automatic idle();
      bus.i_bwd_vld = '0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      idle();
      step();
      step();
      rst = 1'b0;
   endtask
   initial begin
      bus.i_bwd_vld = '0;
      bus.i_bwd_dat = '0;
      bus.i_rdy = 1'b1;
      bus.i_ovf_clr = 1'b0;
      rst = 1'b1;
      step();
      step();
      chk("rst_vld", bus.o_vld, 0);
      chk("rst_dat", bus.o_dat, 0);
      chk("rst_lane", bus.o_lane, 0);
      chk("rst_ovf", bus.o_ovf, 0);
      rst = 1'b0;
      step();
      put(2, 32'hA5A5_0002);
      step();
      idle();
      chk("lat_c1", bus.o_vld, 0);
      step();
      chk("lat_vld", bus.o_vld, 1);
      chk("lat_lane", bus.o_lane, 2);
      chk("lat_dat", bus.o_dat, 64'hA5A5_0002);
      step();
      chk("lat_c3", bus.o_vld, 0);
      do_reset();
      for (int l = 0; l < 4; l++) put(l, 32'h10 + l);
      step();
      idle();
      chk("rr_gap", bus.o_vld, 0);
      step();
      for (int l = 0; l < 4; l++) begin
         chk("rr_vld", bus.o_vld, 1);
         chk("rr_lane", bus.o_lane, l);
         chk("rr_dat", bus.o_dat, 64'h10 + l);
         step();
      end
      chk("rr_end", bus.o_vld, 0);
      bus.i_rdy = 1'b0;
      put(0, 32'h20);
      put(1, 32'h21);
      step();
      idle();
      step();
      for (int c = 0; c < 5; c++) begin
         chk("st_vld", bus.o_vld, 1);
         chk("st_lane", bus.o_lane, 0);
         chk("st_dat", bus.o_dat, 64'h20);
         step();
      end
      bus.i_rdy = 1'b1;
      step();
      chk("st_nvld", bus.o_vld, 1);
      chk("st_nlane", bus.o_lane, 1);
      chk("st_ndat", bus.o_dat, 64'h21);
      step();
      chk("st_end", bus.o_vld, 0);
      bus.i_rdy = 1'b0;
      for (int w = 1; w <= 6; w++) begin
         put(1, w);
         step();
      end
      idle();
      chk("ov_flag", bus.o_ovf, OVF ? 4'b0010 : 4'b0000);
      bus.i_rdy = 1'b1;
      for (int w = 1; w <= 5; w++) begin
         chk("ov_vld", bus.o_vld, 1);
         chk("ov_lane", bus.o_lane, 1);
         chk("ov_dat", bus.o_dat, w);
         step();
      end
      chk("ov_end", bus.o_vld, 0);
      bus.i_rdy = 1'b0;
      for (int w = 0; w < 5; w++) begin
         put(0, 32'h61 + w);
         step();
      end
      idle();
      chk("fp_head", bus.o_dat, 64'h61);
      bus.i_rdy = 1'b1;
      put(0, 32'h77);
      step();
      idle();
      for (int w = 0; w < 5; w++) begin
         chk("fp_lane", bus.o_lane, 0);
         chk("fp_dat", bus.o_dat, w == 4 ? 64'h77 : 64'h62 + w);
         step();
      end
      chk("fp_end", bus.o_vld, 0);
      chk("fp_ovf0", bus.o_ovf[0], 0);
      chk("fp_ovf", bus.o_ovf, OVF ? 4'b0010 : 4'b0000);
      bus.i_rdy = 1'b0;
      put(0, 32'h30);
      put(1, 32'h31);
      put(2, 32'h32);
      step();
      idle();
      step();
      chk("mr_vld", bus.o_vld, 1);
      rst = 1'b1;
      put(3, 32'h3F);
      step();
      chk("mr_rvld", bus.o_vld, 0);
      chk("mr_rovf", bus.o_ovf, 0);
      step();
      rst = 1'b0;
      idle();
      bus.i_rdy = 1'b1;
      step();
      chk("mr_empty", bus.o_vld, 0);
      put(1, 32'h41);
      put(3, 32'h43);
      step();
      idle();
      chk("mr_c1", bus.o_vld, 0);
      step();
      chk("mr_vld1", bus.o_vld, 1);
      chk("mr_lane1", bus.o_lane, 1);
      chk("mr_dat1", bus.o_dat, 64'h41);
      step();
      chk("mr_lane3", bus.o_lane, 3);
      chk("mr_dat3", bus.o_dat, 64'h43);
      step();
      chk("mr_end", bus.o_vld, 0);
      bus.i_rdy = 1'b0;
      for (int w = 1; w <= 6; w++) begin
         put(2, w);
         step();
      end
      idle();
      chk("cl_set", bus.o_ovf, OVF ? 4'b0100 : 4'b0000);
      put(2, 7);
      bus.i_ovf_clr = 1'b1;
      step();
      idle();
      chk("cl_both", bus.o_ovf, OVF ? 4'b0100 : 4'b0000);
      step();
      bus.i_ovf_clr = 1'b0;
      chk("cl_clr", bus.o_ovf, 0);
      chk("cl_hold", bus.o_dat, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
